// File: rtl/mul_div_pkg.sv
// Shared definitions for the multiply/divide datapath: FSM state encoding
// and the step-counter width helper used by seq_divider.
`timescale 1ns/1ps
package mul_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step counter holds DEVIDENT_LENGTH-1 down to 0; never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_cell.sv
// One combinational restoring-division step: subtract the divisor from the
// shifted partial remainder and keep the difference only if it did not borrow.
`timescale 1ns/1ps
module div_cell #(
  parameter int DIVISOR_LENGTH = 3
) (
  input  logic [DIVISOR_LENGTH:0]   r_shift,
  input  logic [DIVISOR_LENGTH-1:0] d,
  output logic [DIVISOR_LENGTH:0]   r_next,
  output logic                      q_bit
);

  logic [DIVISOR_LENGTH+1:0] trial;

  // One guard bit above R makes the top bit a true borrow, so a zero divisor
  // always yields q_bit=1 even when the shifted remainder has its MSB set.
  always_comb begin
    trial  = {1'b0, r_shift} - {2'b00, d};
    q_bit  = ~trial[DIVISOR_LENGTH+1];
    r_next = q_bit ? trial[DIVISOR_LENGTH:0] : r_shift;
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock.
// Optional macro DIV_ZERO_CHECK_EN: zero divisor bypasses RUN and flags DivByZero.
`timescale 1ns/1ps
module seq_divider
  import mul_div_pkg::*;
#(
  parameter int DEVIDENT_LENGTH = 3,
  parameter int DIVISOR_LENGTH  = 3
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       Start,
  input  logic [DIVISOR_LENGTH-1:0]  OperX,
  input  logic [DEVIDENT_LENGTH-1:0] OperY,
  output logic                       Busy,
  output logic                       Done,
  output logic [DEVIDENT_LENGTH-1:0] Quotient,
  output logic [DIVISOR_LENGTH-1:0]  Remainder,
  output logic                       DivByZero,
  output logic [1:0]                 dbg_state
);

  localparam int N  = DEVIDENT_LENGTH;
  localparam int M  = DIVISOR_LENGTH;
  localparam int CW = cnt_width(N);

  // Handshake: Start is sampled only in IDLE (operands captured on that edge);
  // Done pulses for one cycle with the results, which hold until the next Done.
  state_t         state;
  logic [M-1:0]   d_reg;
  logic [N-1:0]   q_reg;
  logic [M:0]     r_reg;
  logic [CW-1:0]  cnt;

  logic [M:0]     r_shift;
  logic [M:0]     r_next;
  logic           q_bit;
  logic           unused_rtop;

  assign dbg_state   = state;
  assign r_shift     = {r_reg[M-1:0], q_reg[N-1]};
  assign unused_rtop = r_reg[M];

`ifdef DIV_ZERO_CHECK_EN
  localparam int W_MAX = (N > M) ? N : M;
  logic             dz_reg;
  logic [W_MAX-1:0] y_ext;
  assign y_ext = W_MAX'(OperY);
`endif

  div_cell #(.DIVISOR_LENGTH(M)) u_cell (
    .r_shift (r_shift),
    .d       (d_reg),
    .r_next  (r_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      d_reg     <= '0;
      q_reg     <= '0;
      r_reg     <= '0;
      cnt       <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
      dz_reg    <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            d_reg <= OperX;
            q_reg <= OperY;
            r_reg <= '0;
            cnt   <= CW'(N - 1);
            Busy  <= 1'b1;
            state <= RUN;
`ifdef DIV_ZERO_CHECK_EN
            dz_reg <= 1'b0;
            // Preload the same values the full iteration would produce.
            if (OperX == '0) begin
              q_reg  <= '1;
              r_reg  <= {1'b0, y_ext[M-1:0]};
              dz_reg <= 1'b1;
              state  <= DONE;
            end
`endif
          end
        end
        RUN: begin
          r_reg <= r_next;
          q_reg <= {q_reg[N-2:0], q_bit};
          cnt   <= cnt - CW'(1);
          if (cnt == '0) state <= DONE;
        end
        DONE: begin
          Done      <= 1'b1;
          Busy      <= 1'b0;
          Quotient  <= q_reg;
          Remainder <= r_reg[M-1:0];
`ifdef DIV_ZERO_CHECK_EN
          DivByZero <= dz_reg;
`else
          DivByZero <= 1'b0;
`endif
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential restoring divider producing one quotient bit per clock, the division counterpart of the array multiplier `mul_div`. It takes an unsigned dividend on `OperY` and divisor on `OperX`, iterates over `DEVIDENT_LENGTH` cycles, and returns quotient and remainder behind a start/done handshake. It sits beside `mul_div` so the datapath covers both operations: the multiplier for combinational products, this block for multi-cycle quotients.

## Interface
- `DEVIDENT_LENGTH`, default 3: dividend and quotient width in bits, minimum 2.
- `DIVISOR_LENGTH`, default 3: divisor and remainder width in bits, minimum 2.
- `CLK` input, 1 bit: single clock, rising edge.
- `RST` input, 1 bit: asynchronous, active-high reset.
- `Start` input, 1 bit: request a division; sampled only in IDLE.
- `OperX` input, `DIVISOR_LENGTH` bits: divisor, unsigned.
- `OperY` input, `DEVIDENT_LENGTH` bits: dividend, unsigned.
- `Busy` output, 1 bit: high while a division is in progress.
- `Done` output, 1 bit: one-cycle pulse when results are valid.
- `Quotient` output, `DEVIDENT_LENGTH` bits: floor(OperY/OperX).
- `Remainder` output, `DIVISOR_LENGTH` bits: OperY mod OperX.
- `DivByZero` output, 1 bit: divisor was zero; valid with `Done`.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - On `Start=1`, latch `OperX` into divisor register D.
  - Load shift register Q with `OperY`.
  - Clear partial remainder R (`DIVISOR_LENGTH+1` bits) and load step counter with `DEVIDENT_LENGTH-1`.
  - Go to RUN.
- **RUN, each cycle:**
  - Shift {R,Q} left one bit.
  - Compute trial = shifted R − zero-extended D.
  - If trial ≥ 0 (MSB clear): R ← trial, Q[0] ← 1.
  - Else: R keeps the shifted value, Q[0] ← 0.
  - Decrement the counter.
  - When the counter is 0 in this cycle, go to DONE.
- **DONE:**
  - `Done=1` for exactly one cycle.
  - `Quotient` ← Q, `Remainder` ← R[`DIVISOR_LENGTH`-1:0].
  - Go to IDLE.
- **Outputs:** `Quotient`, `Remainder` and `DivByZero` are registered and hold their values until the next DONE.
- **`Start` outside IDLE:** ignored. No queuing; operands are not re-sampled.
- **`Start` held high:** a new division begins on the cycle after DONE, when the block is back in IDLE.
- **Divisor 0 with the normal algorithm:** result is `Quotient` all ones and `Remainder` = dividend truncated to `DIVISOR_LENGTH`.
- **Width mismatch:** when `DIVISOR_LENGTH` < `DEVIDENT_LENGTH` and the true remainder fits, `Remainder` is exact. R's extra bit guarantees no overflow of the trial subtraction.

## Timing
- **Reset:** `RST` asserted forces, asynchronously:
  - state to IDLE;
  - `Busy`, `Done`, `DivByZero`, `Quotient`, `Remainder` to 0;
  - all internal registers to 0.
- **Reset mid-operation:** aborts the division; no `Done` is produced.
- **Latency:** `Start` sampled at edge 0, then `Busy=1` from edge 0 through edge `DEVIDENT_LENGTH`. `Done=1` and results update after edge `DEVIDENT_LENGTH+1`, i.e. `DEVIDENT_LENGTH+1` cycles after `Start`.
- **Busy:** high in RUN and DONE, low in IDLE.
- **Throughput:** one division per `DEVIDENT_LENGTH+2` cycles with `Start` held high.

## Configuration
- **Macro:** `DIV_ZERO_CHECK_EN`.
- **Defined:**
  - `OperX == 0` at start skips RUN and goes directly IDLE→DONE.
  - `Done` appears 1 cycle after `Start`.
  - Outputs: `DivByZero=1`, `Quotient` all ones, `Remainder` = `OperY` truncated.
- **Not defined:**
  - No zero check; divisor 0 runs the full RUN sequence and yields the same `Quotient`/`Remainder` values.
  - `DivByZero` is tied to 0.

## Structure
- **Shared package `mul_div_pkg`:**
  - state enum (IDLE, RUN, DONE);
  - counter width, computed as $clog2(`DEVIDENT_LENGTH`).
- **Sub-module `div_cell`:** one combinational restoring step.
  - Inputs: shifted R, D.
  - Outputs: next R and quotient bit.
  - It is instanced once in the RUN datapath and keeps the iteration logic separate from the FSM.

## Test plan
- **7/2 basic division:** reset, then `OperY=3'd7`, `OperX=3'd2`, `Start` pulse → `Done` 4 cycles later, `Quotient=3`, `Remainder=1`, `DivByZero=0`.
- **Exact and zero-quotient results:** 6/3 → `Quotient=2`, `Remainder=0`. Then 5/7 → `Quotient=0`, `Remainder=5`. `Busy` stays low exactly one cycle between runs when `Start` is held high.
- **Divide by zero:** `OperX=0`, `OperY=5`.
  - With `DIV_ZERO_CHECK_EN`: `Done` 1 cycle after `Start`, `DivByZero=1`, `Quotient=7`, `Remainder=5`.
  - Without it: `Done` 4 cycles after `Start`, same values, `DivByZero=0`.
- **Start while busy:** toggle `Start` and change operands during RUN → no effect; result matches the first operands; a single `Done` pulse.
- **Reset mid-run:** assert `RST` asynchronously at cycle 2 of RUN → all outputs 0 immediately; no `Done`. The next `Start` runs normally, e.g. 7/3 → `Quotient=2`, `Remainder=1`.
- **Exhaustive sweep:** with `DEVIDENT_LENGTH=4`, `DIVISOR_LENGTH=3`, all nonzero divisors × all dividends match a reference model.
